// File: rtl/output_scheduler.sv
// Switch output stage: four per-output round-robin arbiters move whole packets from
// four input word streams into four output RAM write ports, plus a busy-cycle counter.
module output_scheduler #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] in_data    [4],
  input  logic [1:0]  in_dest    [4],
  input  logic [3:0]  in_last,
  input  logic [3:0]  in_valid,
  output logic [3:0]  in_ready,
  output logic [31:0] outp       [4],
  output logic [3:0]  out_ram_wr,
  output logic [3:0]  full,
  output logic        busy,
  output logic [31:0] total_time
);

  localparam logic [12:0] DEPTH_CNT = 13'(DEPTH);

  typedef enum logic {IDLE, XFER} state_e;

  state_e      state_q  [4];
  state_e      state_d  [4];
  logic [1:0]  owner_q  [4];
  logic [1:0]  owner_d  [4];
  logic [1:0]  rr_ptr_q [4];
  logic [1:0]  rr_ptr_d [4];
  logic [12:0] cnt_q    [4];
  logic [12:0] cnt_d    [4];
  logic [31:0] stage_q  [4];
  logic [31:0] stage_d  [4];
  logic [31:0] outp_q   [4];
  logic [31:0] outp_d   [4];
  logic [3:0]  wr_q;
  logic [3:0]  wr_d;
  logic [31:0] total_q;
  logic [31:0] total_d;

  logic [3:0]  locked;
  logic [3:0]  accept;
  logic [3:0]  grant_vld;
  logic [1:0]  grant_idx [4];

  always_comb begin
    locked = '0;
    full   = '0;
    for (int j = 0; j < 4; j++) begin
      if (state_q[j] == XFER) locked[owner_q[j]] = 1'b1;
      full[j] = (cnt_q[j] == DEPTH_CNT);
    end
  end

  // Inputs have a single destination, so at most one output drives each in_ready bit.
  always_comb begin
    in_ready = '0;
    accept   = '0;
    for (int j = 0; j < 4; j++) begin
      if (state_q[j] == XFER && !full[j]) begin
        in_ready[owner_q[j]] = 1'b1;
        accept[j]            = in_valid[owner_q[j]];
      end
    end
  end

  always_comb begin
    grant_vld = '0;
    for (int j = 0; j < 4; j++) begin
      grant_idx[j] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        if (!grant_vld[j]) begin
          if (in_valid[rr_ptr_q[j] + 2'(k)] && in_dest[rr_ptr_q[j] + 2'(k)] == 2'(j) &&
              !locked[rr_ptr_q[j] + 2'(k)]) begin
            grant_vld[j] = 1'b1;
            grant_idx[j] = rr_ptr_q[j] + 2'(k);
          end
        end
      end
    end
  end

  always_comb begin
    wr_d = '0;
    for (int j = 0; j < 4; j++) begin
      state_d[j]  = state_q[j];
      owner_d[j]  = owner_q[j];
      rr_ptr_d[j] = rr_ptr_q[j];
      stage_d[j]  = stage_q[j];
      outp_d[j]   = outp_q[j];
      cnt_d[j]    = cnt_q[j];
      wr_d[j]     = accept[j];
      // Data trails the strobe by one cycle to match the RAM's write register.
      if (wr_q[j]) outp_d[j] = stage_q[j];
      if (accept[j]) stage_d[j] = in_data[owner_q[j]];
      if (clear) cnt_d[j] = '0;
      else if (accept[j]) cnt_d[j] = cnt_q[j] + 13'd1;
      case (state_q[j])
        IDLE: begin
          if (run && !full[j] && grant_vld[j]) begin
            state_d[j]  = XFER;
            owner_d[j]  = grant_idx[j];
            rr_ptr_d[j] = grant_idx[j] + 2'd1;
          end
        end
        XFER: begin
          if (accept[j] && in_last[owner_q[j]]) state_d[j] = IDLE;
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (|in_valid);
    for (int j = 0; j < 4; j++) begin
      if (state_q[j] == XFER) busy = 1'b1;
    end
    total_d = total_q;
    if (clear) total_d = '0;
    else if (run && busy && total_q != 32'hFFFF_FFFF) total_d = total_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        state_q[j]  <= IDLE;
        owner_q[j]  <= 2'd0;
        rr_ptr_q[j] <= 2'd0;
        cnt_q[j]    <= '0;
        stage_q[j]  <= '0;
        outp_q[j]   <= '0;
      end
      wr_q    <= '0;
      total_q <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        state_q[j]  <= state_d[j];
        owner_q[j]  <= owner_d[j];
        rr_ptr_q[j] <= rr_ptr_d[j];
        cnt_q[j]    <= cnt_d[j];
        stage_q[j]  <= stage_d[j];
        outp_q[j]   <= outp_d[j];
      end
      wr_q    <= wr_d;
      total_q <= total_d;
    end
  end

  assign outp       = outp_q;
  assign out_ram_wr = wr_q;
  assign total_time = total_q;

endmodule
